// File: rtl/step_sequencer_pkg.sv
// rtl/step_sequencer_pkg.sv - shared control-unit step sequencer types and defaults
package step_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } step_state_t;

    // Also consumed by the control-unit decoder to size its step tables.
    localparam int DEFAULT_WIDTH    = 3;
    localparam int DEFAULT_MAX_STEP = 7;

endpackage

// File: rtl/step_sequencer_if.sv
// rtl/step_sequencer_if.sv - control/status bundle between decoder and step sequencer
interface step_sequencer_if #(
    parameter int WIDTH    = step_sequencer_pkg::DEFAULT_WIDTH,
    parameter int MAX_STEP = step_sequencer_pkg::DEFAULT_MAX_STEP
);
    logic                Run;
    logic                Clear;
    logic                Stall;
    logic                Espera1ciclo;
    logic [WIDTH-1:0]    Tstep;
    logic [MAX_STEP:0]   StepOneHot;
    logic                Busy;
    logic                Done;
    logic                Overflow;

    modport master (
        output Run, Clear, Stall, Espera1ciclo,
        input  Tstep, StepOneHot, Busy, Done, Overflow
    );

    modport slave (
        input  Run, Clear, Stall, Espera1ciclo,
        output Tstep, StepOneHot, Busy, Done, Overflow
    );
endinterface

// File: rtl/step_onehot_decoder.sv
// rtl/step_onehot_decoder.sv - binary step index to gated one-hot step vector
module step_onehot_decoder #(
    parameter int WIDTH    = step_sequencer_pkg::DEFAULT_WIDTH,
    parameter int MAX_STEP = step_sequencer_pkg::DEFAULT_MAX_STEP
) (
    input  logic [WIDTH-1:0]  step,
    input  logic              enable,
    output logic [MAX_STEP:0] onehot
);
    always_comb begin
        onehot = '0;
        if (enable) begin
            for (int i = 0; i <= MAX_STEP; i++) begin
                if (step == WIDTH'(i)) begin
                    onehot[i] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - instruction step sequencer with wait/stall, wrap/saturate and done pulse
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_STEP = DEFAULT_MAX_STEP,
    parameter bit WRAP     = 1'b1
) (
    input  logic Clock,
    input  logic Reset,
    step_sequencer_if.slave bus
);
    generate
        if (MAX_STEP < 1 || MAX_STEP > (2 ** WIDTH) - 1) begin : g_bad_max_step
            $error("step_sequencer: MAX_STEP out of range for WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_STEP);

    step_state_t      state, state_nxt;
    logic [WIDTH-1:0] tstep, tstep_nxt;
    logic             busy, done, overflow;
    logic             done_nxt, overflow_nxt;
    logic             advance, finish;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            tstep    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            tstep    <= tstep_nxt;
            busy     <= (state_nxt == ST_RUN) || (state_nxt == ST_WAIT);
            done     <= done_nxt;
            overflow <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tstep_nxt    = tstep;
        done_nxt     = 1'b0;
        overflow_nxt = overflow;
        advance      = 1'b0;
        finish       = 1'b0;

        case (state)
            ST_IDLE: begin
                tstep_nxt = '0;
                if (bus.Run) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.Clear) begin
                    finish = 1'b1;
                end else if (bus.Espera1ciclo) begin
                    state_nxt = ST_WAIT;
                end else if (!bus.Stall) begin
                    advance = 1'b1;
                end
            end
            ST_WAIT: begin
                // The wait cycle is the held copy of the step; leaving it advances.
                if (bus.Clear) begin
                    finish = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.Clear) begin
                    finish = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (advance) begin
            state_nxt = ST_RUN;
            if (tstep < LAST) begin
                tstep_nxt = tstep + WIDTH'(1);
            end else if (WRAP) begin
                finish = 1'b1;
            end else begin
                overflow_nxt = 1'b1;
                state_nxt    = ST_HALT;
            end
        end

        // Clear and wrap share this path, so coinciding events give one Done.
        if (finish) begin
            tstep_nxt    = '0;
            done_nxt     = 1'b1;
            overflow_nxt = 1'b0;
            state_nxt    = bus.Run ? ST_RUN : ST_IDLE;
        end
    end

    step_onehot_decoder #(
        .WIDTH    (WIDTH),
        .MAX_STEP (MAX_STEP)
    ) u_decoder (
        .step   (tstep),
        .enable (busy),
        .onehot (bus.StepOneHot)
    );

    assign bus.Tstep    = tstep;
    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.Overflow = overflow;
endmodule
